// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state, read owner and default widths.
package arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/grant/read-return bundle between fetch, load/store, the memory macro and the arbiter.
interface mem_port_arbiter_if
  import arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              o_stall;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, o_stall
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, o_stall
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and load/store with starvation guard and pipeline stall.
// Optional saturating perf counters are built when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]        perf_conflicts,
  output logic [15:0]        perf_ls_stall
`endif
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  logic [LAT_W-1:0]  lat_q;
  logic [ST_W-1:0]   starve_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  logic window, rd_done, starved, if_win;
  logic ls_stall_term;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Grant window: idle, or the outstanding read returns this cycle.
  assign rd_done = ~rst & (state_q == BUSY) & (lat_q == '0);
  assign window  = ~rst & ((state_q == IDLE) | (lat_q == '0));
  assign starved = (starve_q == ST_W'(STARVE_MAX));
  assign if_win  = bus.if_req & (~bus.ls_req | starved);

  assign bus.if_gnt    = window & if_win;
  assign bus.ls_gnt    = window & bus.ls_req & ~if_win;
  assign bus.if_rvalid = rd_done & (owner_q == OWN_IF);
  assign bus.ls_rvalid = rd_done & (owner_q == OWN_LS);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : if_rdata_q;
  assign bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : ls_rdata_q;

  assign bus.mem_en    = bus.if_gnt | bus.ls_gnt;
  assign bus.mem_we    = bus.ls_gnt & bus.ls_we;
  assign bus.mem_addr  = bus.ls_gnt ? bus.ls_addr :
                         bus.if_gnt ? bus.if_addr : '0;
  assign bus.mem_wdata = bus.mem_we ? bus.ls_wdata : '0;

  assign ls_stall_term = ~rst & ((bus.ls_req & ~bus.ls_gnt) |
                                 ((state_q == BUSY) & (owner_q == OWN_LS) & ~bus.ls_rvalid));
  assign bus.o_stall   = ls_stall_term | (~rst & bus.if_req & ~bus.if_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      lat_q      <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (bus.if_rvalid) if_rdata_q <= bus.mem_rdata;
      if (bus.ls_rvalid) ls_rdata_q <= bus.mem_rdata;

      if (bus.mem_en & ~bus.mem_we) begin
        state_q <= BUSY;
        owner_q <= bus.ls_gnt ? OWN_LS : OWN_IF;
        lat_q   <= LAT_W'(MEM_LAT - 1);
      end else if (state_q == BUSY) begin
        if (lat_q != '0) lat_q   <= lat_q - 1'b1;
        else             state_q <= IDLE;
      end

      // A fetch that is not waiting cannot be starved, so its counter restarts.
      if (~bus.if_req | bus.if_gnt)       starve_q <= '0;
      else if (bus.ls_gnt & ~starved)     starve_q <= starve_q + 1'b1;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflicts <= '0;
      perf_ls_stall  <= '0;
    end else begin
      if (bus.if_req & bus.ls_req) perf_conflicts <= sat_inc16(perf_conflicts);
      if (ls_stall_term)           perf_ls_stall  <= sat_inc16(perf_ls_stall);
    end
  end
`endif

endmodule
